// File: rtl/mul_iter.sv
// Iterative shift-add multiplier (MUL/MULH/MULHSU/MULHU) with a start/ready handshake.
// Define MUL_ZERO_BYPASS_EN to skip the CALC phase when either operand magnitude is zero.
module mul_iter #(
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] multiplicand_i,
  input  logic [31:0] multiplier_i,
  input  logic        start_i,
  input  logic [3:0]  op_i,
  output logic [31:0] result_o,
  output logic        ready_o,
  output logic        busy_o
);

  localparam int unsigned CALC_CYCLES = 32 / BITS_PER_CYCLE;
  localparam int unsigned CW = 6;

  typedef enum logic [1:0] {StIdle, StCalc, StEnd} state_e;

  state_e        state_q, state_d;
  logic [3:0]    op_q, op_d;
  logic          neg_q, neg_d;
  logic [63:0]   mcand_q, mcand_d;
  logic [31:0]   mplier_q, mplier_d;
  logic [63:0]   acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          op_valid;
  logic          sign1, sign2;
  logic [31:0]   mag1, mag2;
  logic          neg_new;
  logic [63:0]   pp;
  logic [63:0]   prod;

  // op_i must be exactly one-hot; anything else is ignored in IDLE.
  assign op_valid = (op_i != 4'd0) && ((op_i & (op_i - 4'd1)) == 4'd0);
  assign sign1    = multiplicand_i[31];
  assign sign2    = multiplier_i[31];
  assign mag1     = ((op_i[2] | op_i[1]) && sign1) ? (~multiplicand_i + 32'd1) : multiplicand_i;
  assign mag2     = (op_i[2] && sign2) ? (~multiplier_i + 32'd1) : multiplier_i;
  assign neg_new  = op_i[2] ? (sign1 ^ sign2) : (op_i[1] ? sign1 : 1'b0);

  // Multiplicand is pre-shifted each cycle, so bit j of the window weighs mcand_q << j.
  always_comb begin
    pp = '0;
    for (int unsigned j = 0; j < BITS_PER_CYCLE; j++) begin
      if (mplier_q[j]) begin
        pp = pp + (mcand_q << j);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    neg_d    = neg_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start_i && op_valid) begin
          op_d     = op_i;
          neg_d    = neg_new;
          mcand_d  = {32'd0, mag1};
          mplier_d = mag2;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = StCalc;
`ifdef MUL_ZERO_BYPASS_EN
          if (mag1 == 32'd0 || mag2 == 32'd0) begin
            state_d = StEnd;
          end
`endif
        end
      end
      StCalc: begin
        if (!start_i) begin
          state_d = StIdle;
        end else begin
          acc_d    = acc_q + pp;
          mcand_d  = mcand_q << BITS_PER_CYCLE;
          mplier_d = mplier_q >> BITS_PER_CYCLE;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == CW'(CALC_CYCLES - 1)) begin
            state_d = StEnd;
          end
        end
      end
      StEnd: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      op_q     <= '0;
      neg_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign prod    = neg_q ? (~acc_q + 64'd1) : acc_q;
  assign ready_o = (state_q == StEnd);
  assign busy_o  = (state_q != StIdle);

  // Zero outside the ready cycle so the result can be OR-merged with other units.
  always_comb begin
    result_o = '0;
    if (ready_o) begin
      if (op_q[3]) begin
        result_o = prod[31:0];
      end else if (|op_q[2:0]) begin
        result_o = prod[63:32];
      end
    end
  end

endmodule

// File: tb/tb_mul_iter.sv
// Self-checking bench for mul_iter: directed vector table, abort/reset/invalid-op sequences,
// and randomized operations against a sign-extension based 64-bit product model.
module tb_mul_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a_in, b_in;
  logic [3:0]  op_in;
  logic        start, start4;
  logic [31:0] res1, res4;
  logic        rdy, rdy4, bsy, bsy4;

  int total = 0;
  int pass  = 0;

  always #5 clk = ~clk;

  mul_iter #(.BITS_PER_CYCLE(1)) dut (
    .clk            (clk),
    .rst            (rst),
    .multiplicand_i (a_in),
    .multiplier_i   (b_in),
    .start_i        (start),
    .op_i           (op_in),
    .result_o       (res1),
    .ready_o        (rdy),
    .busy_o         (bsy)
  );

  mul_iter #(.BITS_PER_CYCLE(4)) dut4 (
    .clk            (clk),
    .rst            (rst),
    .multiplicand_i (a_in),
    .multiplier_i   (b_in),
    .start_i        (start4),
    .op_i           (op_in),
    .result_o       (res4),
    .ready_o        (rdy4),
    .busy_o         (bsy4)
  );

  localparam logic [3:0] OP_MUL    = 4'b1000;
  localparam logic [3:0] OP_MULH   = 4'b0100;
  localparam logic [3:0] OP_MULHSU = 4'b0010;
  localparam logic [3:0] OP_MULHU  = 4'b0001;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
    else pass++;
  endtask

  // Full 64-bit product from sign- or zero-extended operands.
  function automatic logic [31:0] ref_mul(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      OP_MUL:    begin p = ua * ub; return p[31:0];  end
      OP_MULH:   begin p = sa * sb; return p[63:32]; end
      OP_MULHSU: begin p = sa * ub; return p[63:32]; end
      OP_MULHU:  begin p = ua * ub; return p[63:32]; end
      default:   return 32'd0;
    endcase
  endfunction

  function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b, input int calc);
`ifdef MUL_ZERO_BYPASS_EN
    if (a == 32'd0 || b == 32'd0) return 1;
`endif
    return calc + 1;
  endfunction

  task automatic run(input bit sel4, input logic [3:0] op, input logic [31:0] a,
                     input logic [31:0] b, input int lat, input logic [31:0] exp,
                     input string name);
    int          cyc;
    bit          seen, stray;
    logic [31:0] res;
    @(negedge clk);
    op_in = op;
    a_in  = a;
    b_in  = b;
    if (sel4) start4 = 1'b1;
    else      start  = 1'b1;
    cyc = 0; seen = 1'b0; stray = 1'b0; res = '0;
    while (!seen && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (sel4 ? rdy4 : rdy) begin
        seen = 1'b1;
        res  = sel4 ? res4 : res1;
      end else if ((sel4 ? res4 : res1) != 32'd0) begin
        stray = 1'b1;
      end
      // Inputs after the sampling cycle must not matter.
      if (cyc == 1) begin
        a_in  = $urandom;
        b_in  = $urandom;
        op_in = 4'b0001 << $urandom_range(0, 3);
      end
    end
    check({name, " latency"}, 64'(cyc), 64'(lat));
    check({name, " result"}, 64'(res), 64'(exp));
    check({name, " zero while not ready"}, 64'(stray), 64'd0);
    @(negedge clk);
    start  = 1'b0;
    start4 = 1'b0;
    @(posedge clk);
    #1;
    check({name, " ready/busy drop"},
          64'({sel4 ? rdy4 : rdy, sel4 ? bsy4 : bsy}), 64'd0);
  endtask

  initial begin
    vecs[0] = '{OP_MUL,    32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB};
    vecs[1] = '{OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000};
    vecs[2] = '{OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[3] = '{OP_MULH,   32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF};
    vecs[4] = '{OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[5] = '{OP_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
    vecs[6] = '{OP_MUL,    32'h00000000, 32'h12345678, 32'h00000000};
    vecs[7] = '{OP_MULHU,  32'h12345678, 32'h00000000, 32'h00000000};

    rst = 1'b1; start = 1'b0; start4 = 1'b0;
    a_in = '0; b_in = '0; op_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset outputs", 64'({rdy, bsy, res1, rdy4, bsy4, res4}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle after reset", 64'({rdy, bsy, res1}), 64'd0);

    for (int i = 0; i < 8; i++) begin
      run(1'b0, vecs[i].op, vecs[i].a, vecs[i].b, exp_lat(vecs[i].a, vecs[i].b, 32),
          vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Wider retire rate: same directed cases on the 4-bit-per-cycle instance.
    run(1'b1, vecs[0].op, vecs[0].a, vecs[0].b, exp_lat(vecs[0].a, vecs[0].b, 8),
        vecs[0].exp, "bpc4 mul");
    run(1'b1, vecs[4].op, vecs[4].a, vecs[4].b, exp_lat(vecs[4].a, vecs[4].b, 8),
        vecs[4].exp, "bpc4 mulhsu");
    run(1'b1, vecs[6].op, vecs[6].a, vecs[6].b, exp_lat(vecs[6].a, vecs[6].b, 8),
        vecs[6].exp, "bpc4 zero");

    // Non-one-hot and zero op codes are ignored.
    @(negedge clk);
    op_in = 4'b0011; a_in = 32'd9; b_in = 32'd9; start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("invalid op stays idle", 64'({bsy, rdy}), 64'd0);
    @(negedge clk);
    op_in = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    check("zero op stays idle", 64'({bsy, rdy}), 64'd0);
    @(negedge clk);
    start = 1'b0;

    // Abort in the 10th CALC cycle.
    begin
      bit seen_rdy;
      seen_rdy = 1'b0;
      @(negedge clk);
      op_in = OP_MUL; a_in = 32'h1234; b_in = 32'h5678; start = 1'b1;
      repeat (10) begin
        @(posedge clk);
        #1;
        if (rdy) seen_rdy = 1'b1;
      end
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      #1;
      check("abort no ready", 64'({seen_rdy, rdy, res1}), 64'd0);
      check("abort busy low", 64'(bsy), 64'd0);
    end
    run(1'b0, OP_MUL, 32'd3, 32'd5, 33, 32'h0000000F, "after abort");

    // Asynchronous reset at CALC cycle 20.
    @(negedge clk);
    op_in = OP_MUL; a_in = 32'h00010000; b_in = 32'h00010000; start = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("busy before reset", 64'(bsy), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async reset outputs", 64'({rdy, bsy, res1}), 64'd0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run(1'b0, OP_MUL, 32'h00010000, 32'h00010000, 33, 32'h00000000, "post-reset mul");
    run(1'b0, OP_MULHU, 32'h00010000, 32'h00010000, 33, 32'h00000001, "post-reset mulhu");

    // Randomized operations against the reference model.
    for (int i = 0; i < 24; i++) begin
      logic [3:0]  op;
      logic [31:0] a, b;
      bit          s4;
      op = 4'b0001 << $urandom_range(0, 3);
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'd0;
      if ($urandom_range(0, 7) == 0) b = 32'd0;
      if ($urandom_range(0, 7) == 0) a = 32'h80000000;
      if ($urandom_range(0, 7) == 0) b = 32'hFFFFFFFF;
      s4 = (i % 4 == 3);
      run(s4, op, a, b, exp_lat(a, b, s4 ? 8 : 32), ref_mul(op, a, b),
          $sformatf("rand%0d op%b %h*%h", i, op, a, b));
    end

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
